hc_reduce_acc: RTL
==================

Name: hc_reduce_acc

Overview:
- Downstream consumer of the 16-lane h*C product stage of the full-SSM datapath.
- Sums the N_TILE fp16 products of each tile with a pipelined fp16 adder tree.
- Buffers each tile sum in a small FIFO, then serially accumulates N_TILES tile sums into one fp16 output y (one state-dimension reduction per output element).
- The upstream product stage has no backpressure, so this block accepts one tile per cycle unconditionally and flags overflow.

Parameters:
- DW, 16, fp16 word width.
- N_TILE, 16, lanes per input tile; power of 2, 2..64.
- N_TILES, 4, tiles summed per output y; ≥1.
- ADD_LAT, 6, latency of fp16_add_wrapper (clk, valid_in, a, b, result, valid_out).
- FIFO_DEPTH, 8, tile-sum FIFO entries; power of 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- valid_i  in  1  tile valid; accepted every cycle it is high.
- hC_i  in  N_TILE*DW  lane n at [n*DW +: DW].
- y_o  out  DW  accumulated fp16 sum.
- valid_o  out  1  one-cycle pulse qualifying y_o.
- ovf_o  out  1  sticky FIFO-overflow flag.
- busy_o  out  1  high while any tile is in the tree, FIFO or accumulator.

Behaviour:
- Reset: clock and reset port naming follows the codebase; rst is asynchronous and active-high (fixed). On rst, y_o, valid_o, ovf_o and busy_o = 0; FIFO empty; tile counter 0; state LOAD; tree valid shift register cleared.
- Adder tree:
  - log2(N_TILE) levels of fp16_add_wrapper; TREE_LAT = log2(N_TILE)*ADD_LAT.
  - Tree validity is tracked by a local reset-clearable shift register, not by wrapper valid_out.
  - Fully pipelined: one tile per cycle.
  - Pairing order is fixed: level k adds element 2j with element 2j+1.
- FIFO:
  - A tree output valid at cycle t is written at edge t.
  - It is readable (not empty) from t+1.
  - If the FIFO is full when a write arrives, the tile sum is dropped, ovf_o is set (held until rst), and the tile counter does not advance.
  - A simultaneous pop and write when full does not overflow.
- Accumulator FSM:
  - LOAD:
    - If the FIFO is non-empty, pop: acc <= head; cnt <= 1.
    - If N_TILES==1: y_o <= head and valid_o=1 at the next cycle; stay in LOAD.
    - Otherwise go to READY.
  - READY:
    - If the FIFO is non-empty, pop at cycle t and issue adder(a=acc, b=head); go to WAIT.
  - WAIT:
    - Adder result arrives at t+ADD_LAT; acc <= result; cnt <= cnt+1.
    - If cnt+1 == N_TILES: y_o <= result, valid_o pulses at t+ADD_LAT+1, cnt <= 0, next state LOAD.
    - Otherwise next state READY; the earliest next pop is t+ADD_LAT+1.
- y_o holds its value between pulses.
- Arithmetic: the fp16 add rounding and special values are those of the wrapper. No internal widening; the accumulator is DW bits.
- busy_o = tree valid pipe non-zero OR FIFO non-empty OR state != LOAD OR cnt != 0.
- An asynchronous rst mid-row discards all partial sums and in-flight tiles; no valid_o is emitted for the aborted row.

Optional Feature:
- Macro HC_REDUCE_FTZ_EN.
- When defined: any y_o whose exponent field is 0 and mantissa is non-zero is output as signed zero (sign kept, all other bits 0). The internal accumulator is not flushed.
- When not defined: y_o equals the accumulator value bit-exact.

Test Plan:
- Reset: assert rst mid-stream with 2 tiles in the tree -> all outputs 0 immediately; no valid_o afterward; busy_o=0 after release.
- Basic: with defaults, all lanes 0x3C00 on 4 consecutive cycles 0..3 -> single valid_o at cycle 47 with y_o=0x5400 (64.0); tree outputs 0x4C00 (16.0) at cycles 24..27.
- Mixed signs: lanes alternate 0x3C00/0xBC00 -> tile sums 0x0000, y_o=0x0000; then lane 0=0x4000 only, 4 tiles -> y_o=0x4800 (8.0).
- N_TILES=1 build: one tile of all 0x3800 (0.5) -> y_o=0x4800 (8.0), valid_o one cycle after pop.
- Overflow: FIFO_DEPTH=2, 12 back-to-back tiles -> ovf_o rises on the first dropped write and stays 1; the rows emitted contain only accepted tiles; rst clears ovf_o.
- FTZ: lanes 0x0001 with lane 1 = 0x0001, others 0x0000, N_TILES=1 -> y_o=0x0000 with HC_REDUCE_FTZ_EN, 0x0002 without.

Source files
------------

// File: rtl/fp16_add_wrapper.sv
// fp16_add_wrapper: pipelined IEEE-754 binary16 adder.
// The sum is computed in one combinational stage and then carried through
// ADD_LAT registers, so result/valid_out appear ADD_LAT cycles after a/b/valid_in.
// Rounding is round-to-nearest-even. Subnormals are supported. Any NaN input,
// and inf + -inf, give the quiet NaN 0x7E00. An exact zero from cancellation
// is +0 unless both operands are negative.
// Ports:
//   clk       in   clock (rising edge)
//   valid_in  in   operand qualifier, delayed alongside the data
//   a, b      in   fp16 operands
//   result    out  fp16 sum, ADD_LAT cycles later
//   valid_out out  valid_in delayed by ADD_LAT cycles
module fp16_add_wrapper #(
  parameter int ADD_LAT = 6
) (
  input  logic        clk,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        valid_out
);

  function automatic logic [15:0] fp_add(input logic [15:0] fa, input logic [15:0] fb);
    logic [15:0] x, y;
    logic [5:0]  ex, ey, e, d;
    logic [13:0] mx, my;   // {hidden, mantissa[9:0], guard, round, sticky}
    logic [14:0] s;
    logic [11:0] r;
    logic        up, a_nan, b_nan, a_inf, b_inf;
    a_nan = (fa[14:10] == 5'h1f) && (fa[9:0] != 10'h0);
    b_nan = (fb[14:10] == 5'h1f) && (fb[9:0] != 10'h0);
    a_inf = (fa[14:10] == 5'h1f) && (fa[9:0] == 10'h0);
    b_inf = (fb[14:10] == 5'h1f) && (fb[9:0] == 10'h0);
    if (a_nan || b_nan || (a_inf && b_inf && (fa[15] != fb[15]))) return 16'h7e00;
    if (a_inf) return fa;
    if (b_inf) return fb;
    // x is the operand of larger magnitude; its sign is the result sign.
    if (fa[14:0] >= fb[14:0]) begin
      x = fa; y = fb;
    end else begin
      x = fb; y = fa;
    end
    ex = (x[14:10] == 5'h0) ? 6'd1 : {1'b0, x[14:10]};
    ey = (y[14:10] == 5'h0) ? 6'd1 : {1'b0, y[14:10]};
    mx = {(x[14:10] != 5'h0), x[9:0], 3'b000};
    my = {(y[14:10] != 5'h0), y[9:0], 3'b000};
    d  = ex - ey;
    // Align y; bits shifted out collapse into the sticky LSB.
    for (int i = 0; i < 31; i++) begin
      if (i < int'(d)) my = {1'b0, my[13:2], my[1] | my[0]};
    end
    if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, my};
    else                s = {1'b0, mx} - {1'b0, my};
    if (s == 15'h0) return {x[15] & y[15], 15'h0};
    e = ex;
    if (s[14]) begin
      s = {1'b0, s[14:2], s[1] | s[0]};
      e = e + 6'd1;
    end else begin
      // Left-normalise, stopping at the subnormal exponent.
      for (int i = 0; i < 13; i++) begin
        if (!s[13] && (e > 6'd1)) begin
          s = s << 1;
          e = e - 6'd1;
        end
      end
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    r  = {1'b0, s[13:3]} + {11'h0, up};
    if (r[11]) begin
      r = {1'b0, r[11:1]};
      e = e + 6'd1;
    end
    if (e >= 6'd31) return {x[15], 5'h1f, 10'h0};
    // A clear hidden bit means the result stayed subnormal.
    return {x[15], (r[10] ? e[4:0] : 5'h0), r[9:0]};
  endfunction

  logic [15:0]        rpipe [ADD_LAT];
  logic [ADD_LAT-1:0] vpipe;

  always_ff @(posedge clk) begin
    rpipe[0] <= fp_add(a, b);
    vpipe[0] <= valid_in;
    for (int i = 1; i < ADD_LAT; i++) begin
      rpipe[i] <= rpipe[i-1];
      vpipe[i] <= vpipe[i-1];
    end
  end

  assign result    = rpipe[ADD_LAT-1];
  assign valid_out = vpipe[ADD_LAT-1];

endmodule

// File: rtl/hc_reduce_acc.sv
// hc_reduce_acc: reduces the N_TILE fp16 h*C products of each tile with a
// pipelined adder tree, buffers the tile sums in a FIFO and serially
// accumulates N_TILES tile sums into one fp16 output y.
// Optional feature macro: HC_REDUCE_FTZ_EN -- when defined, a subnormal y_o is
// flushed to signed zero (the internal accumulator is left untouched).
//
// Handshake: there is no ready. valid_i qualifies hC_i on every rising edge
// it is high and the tile is always taken; if the tile-sum FIFO is full when
// that tile leaves the tree, the sum is dropped and ovf_o sticks high until
// rst. valid_o is a one-cycle pulse qualifying y_o; y_o holds between pulses.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   valid_i   in   tile valid
//   hC_i      in   N_TILE lanes, lane n at [n*DW +: DW]
//   y_o       out  accumulated fp16 sum
//   valid_o   out  pulse qualifying y_o
//   ovf_o     out  sticky FIFO-overflow flag
//   busy_o    out  work in tree, FIFO or accumulator
//   dbg_state out  accumulator FSM state (0 LOAD, 1 READY, 2 WAIT)
module hc_reduce_acc #(
  parameter int DW         = 16,
  parameter int N_TILE     = 16,
  parameter int N_TILES    = 4,
  parameter int ADD_LAT    = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  input  logic [N_TILE*DW-1:0] hC_i,
  output logic [DW-1:0]      y_o,
  output logic               valid_o,
  output logic               ovf_o,
  output logic               busy_o,
  output logic [1:0]         dbg_state
);

  localparam int LVLS     = $clog2(N_TILE);
  localparam int TREE_LAT = LVLS * ADD_LAT;
  localparam int PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW       = $clog2(FIFO_DEPTH + 1);
  localparam int NW       = $clog2(N_TILES + 1);
  localparam int WW       = $clog2(ADD_LAT + 1);

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_READY = 2'd1, S_WAIT = 2'd2} state_t;

  // Adder tree as a heap: leaves at N_TILE..2*N_TILE-1, node i = node 2i + node 2i+1,
  // which pairs element 2j with 2j+1 at every level; node 1 is the tile sum.
  logic [DW-1:0]       node [1:2*N_TILE-1];
  logic [N_TILE-1:1]   tree_vout_unused;

  for (genvar n = 0; n < N_TILE; n++) begin : g_leaf
    assign node[N_TILE+n] = hC_i[n*DW +: DW];
  end

  for (genvar i = 1; i < N_TILE; i++) begin : g_tree
    fp16_add_wrapper #(.ADD_LAT(ADD_LAT)) u_add (
      .clk       (clk),
      .valid_in  (1'b1),
      .a         (node[2*i]),
      .b         (node[2*i+1]),
      .result    (node[i]),
      .valid_out (tree_vout_unused[i])
    );
  end

  // Tree occupancy is tracked here so rst clears it; the wrapper pipes have no reset.
  logic [TREE_LAT-1:0] tvalid;
  logic                tree_vld;
  logic [DW-1:0]       tree_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tvalid <= '0;
    else     tvalid <= (tvalid << 1) | TREE_LAT'(valid_i);
  end

  assign tree_vld = tvalid[TREE_LAT-1];
  assign tree_sum = node[1];

  // Tile-sum FIFO.
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic          full, empty, pop, push_ok;
  logic [DW-1:0] head;
  state_t        state;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rp];
  assign pop     = ((state == S_LOAD) || (state == S_READY)) && !empty;
  // A pop in the same cycle frees the slot, so a write into a full FIFO survives.
  assign push_ok = tree_vld && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= tree_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf_o <= 1'b0;
    end else begin
      if (push_ok) wp <= nxt(wp);
      if (pop)     rp <= nxt(rp);
      count <= count + CW'(push_ok) - CW'(pop);
      if (tree_vld && full && !pop) ovf_o <= 1'b1;
    end
  end

  // Accumulator.
  logic [DW-1:0] acc, acc_sum;
  logic [NW-1:0] cnt;
  logic [WW-1:0] wcnt;
  logic          acc_vout_unused;

  fp16_add_wrapper #(.ADD_LAT(ADD_LAT)) u_acc_add (
    .clk       (clk),
    .valid_in  ((state == S_READY) && !empty),
    .a         (acc),
    .b         (head),
    .result    (acc_sum),
    .valid_out (acc_vout_unused)
  );

  function automatic logic [DW-1:0] out_fmt(input logic [DW-1:0] v);
`ifdef HC_REDUCE_FTZ_EN
    if ((v[DW-2:DW-6] == 5'h0) && (v[DW-7:0] != '0)) return {v[DW-1], {(DW-1){1'b0}}};
    return v;
`else
    return v;
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_LOAD;
      acc     <= '0;
      cnt     <= '0;
      wcnt    <= '0;
      y_o     <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        S_LOAD: begin
          if (!empty) begin
            acc <= head;
            if (N_TILES == 1) begin
              y_o     <= out_fmt(head);
              valid_o <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt   <= NW'(1);
              state <= S_READY;
            end
          end
        end
        S_READY: begin
          if (!empty) begin
            wcnt  <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // wcnt reaches ADD_LAT-1 in the cycle the adder result is presented.
          if (wcnt == WW'(ADD_LAT - 1)) begin
            acc <= acc_sum;
            if (cnt + NW'(1) == NW'(N_TILES)) begin
              y_o     <= out_fmt(acc_sum);
              valid_o <= 1'b1;
              cnt     <= '0;
              state   <= S_LOAD;
            end else begin
              cnt   <= cnt + NW'(1);
              state <= S_READY;
            end
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  assign busy_o    = (|tvalid) || !empty || (state != S_LOAD) || (cnt != '0);
  assign dbg_state = state;

endmodule
